mc_mips_core: RTL and testbench

//  Next-generation multicycle MIPS-subset core: datapath and control FSM in one block.

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_ctrl.sv | 154 +++++++++++++++
 rtl/mc_mips_core.sv | 101 ++++++++++
 tb/tb_mc_mips_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types, encodings and small helpers for the multicycle MIPS-subset core.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BEQ, S_BNE, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
    ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_ctrl_t;

  typedef enum logic {SRCA_PC = 1'b0, SRCA_A = 1'b1} srca_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMMSL2} srcb_t;
  typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP} pcsrc_t;

  // R-type functs the ALU decoder understands; anything else traps.
  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic alu_ctrl_t funct_alu(input logic [5:0] f);
    alu_ctrl_t c;
    case (f)
      FN_SUB:  c = ALU_SUB;
      FN_AND:  c = ALU_AND;
      FN_OR:   c = ALU_OR;
      FN_SLT:  c = ALU_SLT;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  // 32-bit wrapping ALU; slt is a signed compare.
  function automatic logic [31:0] alu_eval(input alu_ctrl_t ctl, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    case (ctl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Control FSM and main/ALU decoders for the multicycle core.
module mc_ctrl import mc_pkg::*; #(
  parameter bit HAS_BNE  = 1'b1,
  parameter bit HAS_ADDI = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      mem_ready,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic      zero,
  output logic      pcen,
  output logic      irwrite,
  output logic      iord,
  output logic      regdst,
  output logic      memtoreg,
  output logic      regwrite,
  output srca_t     alusrca,
  output srcb_t     alusrcb,
  output alu_ctrl_t alucontrol,
  output pcsrc_t    pcsrc,
  output logic      aluouten,
  output logic      mem_req,
  output logic      mem_we,
  output logic      retire_p,
  output logic      trap
);

  state_t state_q, dec_state;
  logic   trap_q;

  // Main decoder: where DECODE goes for the current opcode/funct.
  always_comb begin
    dec_state = S_TRAP;
    case (op)
      OP_LW, OP_SW: dec_state = S_MEMADR;
      OP_RTYPE:     dec_state = funct_ok(funct) ? S_EXEC : S_TRAP;
      OP_BEQ:       dec_state = S_BEQ;
      OP_BNE:       dec_state = HAS_BNE ? S_BNE : S_TRAP;
      OP_ADDI:      dec_state = HAS_ADDI ? S_ADDIEX : S_TRAP;
      OP_J:         dec_state = S_JUMP;
      default:      dec_state = S_TRAP;
    endcase
  end

  // State register and sticky trap flag; memory states hold until ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          state_q <= dec_state;
          trap_q  <= (dec_state == S_TRAP);
        end
        S_MEMADR: state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign trap = trap_q;

  // Per-state datapath controls; every side effect is squashed while in reset.
  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b1;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_B;
    alucontrol = ALU_ADD;
    pcsrc      = PCSRC_ALU;
    aluouten   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    retire_p   = 1'b0;
    case (state_q)
      S_FETCH: begin
        iord    = 1'b0;
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        pcen    = mem_ready;
        irwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb  = SRCB_IMMSL2;
        aluouten = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca  = SRCA_A;
        alusrcb  = SRCB_IMM;
        aluouten = 1'b1;
      end
      S_MEMRD: mem_req = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire_p = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        retire_p = mem_ready;
      end
      S_EXEC: begin
        alusrca    = SRCA_A;
        alucontrol = funct_alu(funct);
        aluouten   = 1'b1;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire_p = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca    = SRCA_A;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = (state_q == S_BEQ) ? zero : !zero;
        retire_p   = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire_p = 1'b1;
      end
      S_JUMP: begin
        pcsrc    = PCSRC_JUMP;
        pcen     = 1'b1;
        retire_p = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      aluouten = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      retire_p = 1'b0;
    end
  end

endmodule

// File: rtl/mc_mips_core.sv
// Multicycle MIPS-subset core: shared-memory datapath plus mc_ctrl FSM.
module mc_mips_core import mc_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          HAS_BNE  = 1'b1,
  parameter bit          HAS_ADDI = 1'b1,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      adr,
  output logic [31:0]      writedata,
  input  logic             mem_ready,
  input  logic [31:0]      readdata,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic             retire_p
);

  logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, data_q, aluout_q;
  logic [CNT_W-1:0] retired_q;
  logic [31:0] rf [32];

  logic        pcen, irwrite, iord, regdst, memtoreg, regwrite, aluouten, zero;
  srca_t       alusrca;
  srcb_t       alusrcb;
  alu_ctrl_t   alucontrol;
  pcsrc_t      pcsrc;
  logic [4:0]  rs, rt, rd, wa;
  logic [31:0] signimm, rd1, rd2, srca, srcb, aluresult, wd;

  mc_ctrl #(.HAS_BNE(HAS_BNE), .HAS_ADDI(HAS_ADDI)) u_ctrl (
    .clk(clk), .reset(reset), .mem_ready(mem_ready),
    .op(ir_q[31:26]), .funct(ir_q[5:0]), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
    .aluouten(aluouten), .mem_req(mem_req), .mem_we(mem_we),
    .retire_p(retire_p), .trap(trap)
  );

  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rd1     = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd2     = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign wa      = regdst ? rd : rt;
  assign wd      = memtoreg ? data_q : aluout_q;
  assign srca    = (alusrca == SRCA_A) ? a_q : pc_q;

  // ALU operand B select and next-PC select.
  always_comb begin
    case (alusrcb)
      SRCB_B:    srcb = b_q;
      SRCB_FOUR: srcb = 32'd4;
      SRCB_IMM:  srcb = signimm;
      default:   srcb = {signimm[29:0], 2'b00};
    endcase
    aluresult = alu_eval(alucontrol, srca, srcb);
    case (pcsrc)
      PCSRC_ALUOUT: pc_d = aluout_q;
      PCSRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:      pc_d = aluresult;
    endcase
  end

  assign zero = (aluresult == 32'd0);

  // Register file; $0 is never written and reads as zero.
  always_ff @(posedge clk) begin
    if (regwrite && wa != 5'd0) rf[wa] <= wd;
  end

  // Architectural and non-architectural datapath registers plus retire counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      data_q    <= 32'd0;
      aluout_q  <= 32'd0;
      retired_q <= '0;
    end else begin
      if (pcen)     pc_q     <= pc_d;
      if (irwrite)  ir_q     <= readdata;
      a_q <= rd1;
      b_q <= rd2;
      if (aluouten) aluout_q <= aluresult;
      if (mem_req && iord && !mem_we && mem_ready) data_q <= readdata;
      if (retire_p) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_mips_core.sv
// Directed bench for mc_mips_core with a shared word memory and programmable wait states.
module tb_mc_mips_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int rdy_mode = 0;  // 0: always ready, 1: every 3rd cycle, 2: never
  int cyc = 0;
  always @(negedge clk) cyc++;

  logic mem_ready;
  assign mem_ready = (rdy_mode == 0) || (rdy_mode == 1 && (cyc % 3) == 0);

  logic [31:0] mem [0:127];

  logic        mem_req, mem_we, trap, retire_p;
  logic [31:0] adr, writedata, readdata, retired;
  logic        mem_req2, mem_we2, trap2, retire_p2;
  logic [31:0] adr2, writedata2, readdata2;
  logic [1:0]  retired2;

  assign readdata  = mem[adr[8:2]];
  assign readdata2 = mem[adr2[8:2]];

  mc_mips_core #(.RESET_PC(32'h0), .HAS_BNE(1'b1), .HAS_ADDI(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .adr(adr),
    .writedata(writedata), .mem_ready(mem_ready), .readdata(readdata),
    .trap(trap), .retired(retired), .retire_p(retire_p)
  );

  // Second core: non-zero reset PC, no ADDI, 2-bit retire counter.
  mc_mips_core #(.RESET_PC(32'h80), .HAS_BNE(1'b1), .HAS_ADDI(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_we(mem_we2), .adr(adr2),
    .writedata(writedata2), .mem_ready(mem_ready), .readdata(readdata2),
    .trap(trap2), .retired(retired2), .retire_p(retire_p2)
  );

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory write port, fetch log and hold-while-waiting monitor for the main core.
  int          wr_cnt = 0, hold_err = 0;
  logic [31:0] wr_adr = 0, wr_dat = 0, prev_adr = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] fq[$];
  always @(posedge clk) begin
    if (reset && mem_req && mem_we && mem_ready) begin
      mem[adr[8:2]] = writedata;
      wr_cnt++;
      wr_adr = adr;
      wr_dat = writedata;
    end
    if (reset && mem_req && !mem_we && mem_ready) fq.push_back(adr);
    if (reset && prev_wait && (!mem_req || adr != prev_adr)) hold_err++;
    prev_wait = reset && mem_req && !mem_ready;
    prev_adr  = adr;
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  task automatic load_prog_a();
    mem[0] = itype(6'b001000, 5'd0, 5'd2, 16'd5);     // addi $2,$0,5
    mem[1] = itype(6'b001000, 5'd0, 5'd3, 16'd12);    // addi $3,$0,12
    mem[2] = rtype(5'd2, 5'd3, 5'd4, 6'b100000);      // add  $4,$2,$3
    mem[3] = itype(6'b101011, 5'd0, 5'd4, 16'd84);    // sw   $4,84($0)
    mem[4] = itype(6'b000100, 5'd0, 5'd0, 16'hffff);  // beq  $0,$0,-1
    mem[21] = 32'd0;
  endtask

  // Assert reset at a negedge, check outputs drop at once, hold n cycles, then release.
  task automatic do_reset(input int n, input int mode_after);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_now", mem_req, 1'b0);
    check("rst_we_now", mem_we, 1'b0);
    rdy_mode = mode_after;
    repeat (n) begin
      @(negedge clk);
      check("rst_req", mem_req, 1'b0);
      check("rst_trap", trap, 1'b0);
    end
    reset = 1'b1;
    #1;
  endtask

  int w0, fb, n;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    load_prog_a();
    for (int i = 32; i < 37; i++) mem[i] = itype(6'b000100, 5'd0, 5'd0, 16'd0); // beq +0
    mem[37] = itype(6'b001000, 5'd0, 5'd0, 16'd5);                             // addi, traps in dut2

    // 1: reset with ready high, then first fetch cycle
    do_reset(3, 0);
    check("t1_req", mem_req, 1'b1);
    check("t1_adr", adr, 32'h0);
    check("t1_ret", retired, 32'd0);
    check("t1_adr2", adr2, 32'h80);
    check("t1_trap2", trap2, 1'b0);

    // 2: zero-wait program; dut2 runs branches into a wrapping counter then traps
    w0 = wr_cnt;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 3)  check("t2_retp_on", retire_p, 1'b1);
      if (i == 4)  check("t2_retp_off", retire_p, 1'b0);
      if (i == 9)  check("t2_ret2_3", retired2, 2'd3);
      if (i == 11) check("t2_retp2", retire_p2, 1'b1);
      if (i == 12) check("t2_ret2_wrap", retired2, 2'd0);
      if (i == 15) begin
        check("t2_we", mem_we, 1'b1);
        check("t2_wadr", adr, 32'd84);
        check("t2_wdata", writedata, 32'd17);
      end
      if (i == 16) begin
        check("t2_ret", retired, 32'd4);
        check("t2_wcnt", wr_cnt - w0, 32'd1);
        check("t2_wradr", wr_adr, 32'd84);
        check("t2_wrdat", wr_dat, 32'd17);
        check("t2_mem", mem[21], 32'd17);
        check("t2_trap2_pre", trap2, 1'b0);
      end
      if (i == 17) begin
        check("t2_trap2", trap2, 1'b1);
        check("t2_req2", mem_req2, 1'b0);
        check("t2_we2", mem_we2, 1'b0);
        check("t2_wd2", writedata2, 32'd0);
      end
      if (i == 18) begin
        check("t2_req2_stay", mem_req2, 1'b0);
        check("t2_ret2_frozen", retired2, 2'd1);
      end
    end

    // 3: same program with ready every 3rd cycle
    load_prog_a();
    do_reset(2, 1);
    w0 = wr_cnt;
    n = 0;
    while (wr_cnt == w0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_wcnt", wr_cnt - w0, 32'd1);
    check("t3_wradr", wr_adr, 32'd84);
    check("t3_wrdat", wr_dat, 32'd17);
    check("t3_mem", mem[21], 32'd17);
    check("t3_ret", retired, 32'd4);
    check("t3_slow", n > 16, 1'b1);
    check("t3_hold", hold_err, 32'd0);

    // 4: beq taken, bne not taken, j
    mem[0]  = itype(6'b000100, 5'd0, 5'd0, 16'd2);    // beq $0,$0,+2
    mem[3]  = itype(6'b000101, 5'd2, 5'd2, 16'd2);    // bne $2,$2,+2
    mem[4]  = {6'b000010, 26'h40};                     // j 0x40
    mem[64] = itype(6'b000100, 5'd0, 5'd0, 16'hffff);
    do_reset(2, 0);
    fb = fq.size();
    repeat (10) @(negedge clk);
    check("t4_nfetch", fq.size() - fb, 32'd4);
    if (fq.size() - fb >= 4) begin
      check("t4_beq", fq[fb+1], 32'd12);
      check("t4_bne", fq[fb+2], 32'd16);
      check("t4_j", fq[fb+3], 32'h100);
    end
    check("t4_ret", retired, 32'd3);

    // 5: illegal opcode traps after DECODE
    mem[0] = 32'hFC00_0000;
    do_reset(2, 0);
    @(negedge clk);
    check("t5_trap_pre", trap, 1'b0);
    @(negedge clk);
    check("t5_trap", trap, 1'b1);
    check("t5_req", mem_req, 1'b0);
    repeat (5) @(negedge clk);
    check("t5_req_stay", mem_req, 1'b0);
    check("t5_ret", retired, 32'd0);
    check("t5_trap_stay", trap, 1'b1);

    // 6: reset during a MEMWR wait, then $0 write discarded
    load_prog_a();
    do_reset(2, 0);
    w0 = wr_cnt;
    repeat (15) @(negedge clk);
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    check("t6_wait_req", mem_req, 1'b1);
    check("t6_wait_we", mem_we, 1'b1);
    check("t6_wait_adr", adr, 32'd84);
    mem[0]  = rtype(5'd2, 5'd3, 5'd0, 6'b100000);     // add $0,$2,$3
    mem[1]  = itype(6'b101011, 5'd0, 5'd0, 16'd88);   // sw  $0,88($0)
    mem[2]  = itype(6'b000100, 5'd0, 5'd0, 16'hffff);
    mem[22] = 32'hDEAD_BEEF;
    do_reset(2, 0);
    check("t6_nowrite", wr_cnt - w0, 32'd0);
    check("t6_restart_adr", adr, 32'h0);
    check("t6_restart_req", mem_req, 1'b1);
    repeat (8) @(negedge clk);
    check("t6_wcnt", wr_cnt - w0, 32'd1);
    check("t6_wradr", wr_adr, 32'd88);
    check("t6_r0", wr_dat, 32'd0);
    check("t6_mem", mem[22], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
